// File: rtl/counter_job_arbiter_if.sv
// Requester-side job handshake plus the shared counter's LOAD/VALUE/C pins.
// The master side is the requesting logic together with the counter itself.
interface counter_job_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] start_value;
    logic [N_REQ*WIDTH-1:0] end_value;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   cnt_load;
    logic [WIDTH-1:0]       cnt_value;
    logic [WIDTH-1:0]       cnt_c;

    modport master (
        output req, start_value, end_value, cnt_c,
        input  gnt, done, busy, cnt_load, cnt_value
    );

    modport slave (
        input  req, start_value, end_value, cnt_c,
        output gnt, done, busy, cnt_load, cnt_value
    );
endinterface

// File: rtl/counter_job_arbiter.sv
// Round-robin arbiter sharing one enable-less up-counter between N_REQ requesters.
// A granted job loads its start value, runs the counter and freezes it on the end value.
module counter_job_arbiter #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    counter_job_arbiter_if.slave  bus_if
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_e;

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             owner_q, owner_d;
    logic [IDX_W-1:0]             rr_q, rr_d;
    logic [WIDTH-1:0]             s_q, s_d;
    logic [WIDTH-1:0]             e_q, e_d;
    logic [N_REQ-1:0]             gnt_q, gnt_d;
    logic [N_REQ-1:0]             done_q, done_d;

    logic [N_REQ-1:0][WIDTH-1:0]  start_arr;
    logic [N_REQ-1:0][WIDTH-1:0]  end_arr;
    logic [IDX_W-1:0]             win_idx;
    logic [IDX_W-1:0]             rr_next;
    logic                         win_found;
    logic                         abort;
    logic                         match;

    assign start_arr = bus_if.start_value;
    assign end_arr   = bus_if.end_value;
    assign abort     = !bus_if.req[owner_q];
    assign match     = (bus_if.cnt_c == e_q);
    assign rr_next   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Scanning offsets from far to near lets the requester closest to rr_q win.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = rr_q;
        idx       = 0;
        cand      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= N_REQ) idx -= N_REQ;
            cand = IDX_W'(idx);
            if (bus_if.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // NOTE: non-blocking assignments make every register update at the same edge,
    // so no register sees another's new value within the cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            s_q     <= '0;
            e_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            s_q     <= s_d;
            e_q     <= e_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        s_d     = s_q;
        e_d     = e_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    s_d     = start_arr[win_idx];
                    e_d     = end_arr[win_idx];
                    gnt_d   = N_REQ'(1) << win_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    gnt_d   = '0;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // An abort outranks a match seen in the same cycle.
                if (abort) begin
                    gnt_d   = '0;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else if (match) begin
                    done_d  = gnt_q;
                    state_d = FIN;
                end
            end
            FIN: begin
                gnt_d   = '0;
                rr_d    = rr_next;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The counter has no enable: holding it means reloading its own output.
    always_comb begin
        bus_if.cnt_load  = 1'b1;
        bus_if.cnt_value = bus_if.cnt_c;
        case (state_q)
            LOAD:    if (!abort) bus_if.cnt_value = s_q;
            RUN:     if (!abort && !match) bus_if.cnt_load = 1'b0;
            default: ;
        endcase
    end

    assign bus_if.gnt  = gnt_q;
    assign bus_if.done = done_q;
    assign bus_if.busy = (state_q != IDLE);
endmodule
